// File: rtl/fire_pkg.sv
// Types, constants and the shift/saturate helper shared by the fire squeeze/expand engines.
package fire_pkg;

    localparam int FIRE_WIDTH      = 16;
    localparam int FIRE3_SQ_PIXELS = 3025;
    localparam int SAT_W           = 64;

    typedef logic signed [FIRE_WIDTH-1:0] act_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Arithmetic shift right (floor), then clamp into a signed 'width'-bit range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac,
        input int                      width
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        shifted = acc >>> frac;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        if (shifted > hi) begin
            return hi;
        end
        if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/fire_mac_lane.sv
// One output channel: signed MAC over all input channels, then shift/saturate into a registered result.
// Optional FIRE3_SQUEEZE_RELU_EN clamps negative results to zero.
module fire_mac_lane
    import fire_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 39
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] i_act,
    input  logic signed [WIDTH-1:0] i_wgt,
    input  logic                    i_acc_en,
    input  logic                    i_last,
    output logic signed [WIDTH-1:0] o_res
);

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [SAT_W-1:0]   w_sum_x;
    logic signed [WIDTH-1:0]   w_sat;
    logic signed [WIDTH-1:0]   w_res;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [WIDTH-1:0]   r_res;

    assign w_prod  = i_act * i_wgt;
    assign w_sum   = r_acc + {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_sum_x = {{(SAT_W-ACC_W){w_sum[ACC_W-1]}}, w_sum};
    assign w_sat   = WIDTH'(sat_shift(w_sum_x, FRAC, WIDTH));

`ifdef FIRE3_SQUEEZE_RELU_EN
    assign w_res = w_sat[WIDTH-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    // The final beat's product is folded in before the result is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_res <= '0;
        end else if (i_acc_en) begin
            if (i_last) begin
                r_acc <= '0;
                r_res <= w_res;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/fire3_squeeze_mac.sv
// fire3 1x1 squeeze engine: channel counter drives the weight ROM, NUM lanes accumulate, result held until taken.
// Build option: define FIRE3_SQUEEZE_RELU_EN to apply ReLU inside each lane.
module fire3_squeeze_mac
    import fire_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR   = 7,
    parameter int NUM    = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 2*WIDTH + ADDR,
    parameter int PIXELS = FIRE3_SQ_PIXELS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] act_in,
    input  logic                    act_valid,
    output logic                    act_ready,
    output logic [ADDR-1:0]         rom_addr,
    input  logic signed [WIDTH-1:0] rom_data [0:NUM-1],
    output logic signed [WIDTH-1:0] res_out  [0:NUM-1],
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_last,
    output logic                    busy
);

    localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADDR-1:0]  r_ch_cnt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic             r_res_valid;
    logic             r_res_last;
    logic             w_act_ready;
    logic             w_accept;
    logic             w_last_ch;
    logic             w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_act_ready = 1'b0;
        case (r_state)
            ACCUM: begin
                w_act_ready = 1'b1;
                if (act_valid && (&r_ch_cnt)) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    assign w_accept  = act_valid & w_act_ready;
    assign w_last_ch = w_accept & (&r_ch_cnt);
    assign w_hs      = r_res_valid & res_ready;

    // Channel counter wraps on its own after the last channel; result flags only change in opposite states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_cnt    <= '0;
            r_pix_cnt   <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ch_cnt <= r_ch_cnt + 1'b1;
            end
            if (w_last_ch) begin
                r_res_valid <= 1'b1;
                r_res_last  <= (r_pix_cnt == PIX_W'(PIXELS - 1));
            end else if (w_hs) begin
                r_res_valid <= 1'b0;
                r_res_last  <= 1'b0;
                r_pix_cnt   <= (r_pix_cnt == PIX_W'(PIXELS - 1)) ? '0 : r_pix_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        fire_mac_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_act    (act_in),
            .i_wgt    (rom_data[g]),
            .i_acc_en (w_accept),
            .i_last   (w_last_ch),
            .o_res    (res_out[g])
        );
    end

    assign act_ready = w_act_ready;
    assign rom_addr  = r_ch_cnt;
    assign res_valid = r_res_valid;
    assign res_last  = r_res_last;
    assign busy      = (r_ch_cnt != '0) | r_res_valid;

endmodule

// File: tb/tb_fire3_squeeze_mac.sv
// Scoreboard bench for fire3_squeeze_mac: driver pushes expected vectors, monitor pops on each result handshake.
module tb_fire3_squeeze_mac;

    localparam int W    = 16;
    localparam int A    = 7;
    localparam int N    = 16;
    localparam int CH   = 128;
    localparam int PIXN = 4;

    typedef struct packed {
        logic [N*W-1:0] v;
        logic           last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] act_in = '0;
    logic                act_valid = 1'b0;
    logic                act_ready;
    logic [A-1:0]        rom_addr;
    logic signed [W-1:0] rom_data [0:N-1];
    logic signed [W-1:0] res_out  [0:N-1];
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic                res_last;
    logic                busy;

    logic signed [W-1:0] w_tab [0:CH-1][0:N-1];
    exp_t                exp_q [$];
    int                  n_checks = 0;
    int                  n_pass = 0;
    int                  exp_pix = 0;

    fire3_squeeze_mac #(
        .WIDTH  (W),
        .ADDR   (A),
        .NUM    (N),
        .FRAC   (8),
        .PIXELS (PIXN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_in    (act_in),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .res_out   (res_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_last  (res_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) rom_data[i] = w_tab[rom_addr][i];
    end

    task automatic chk(input string nm, input bit ok, input longint act_v, input longint exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    endtask

    // Reference: exact sum, floor divide by 2^8, clamp to 16-bit signed, optional ReLU.
    function automatic longint ref_result(input longint sum);
        longint q;
        q = sum / 256;
        if (sum < 0 && q * 256 != sum) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`ifdef FIRE3_SQUEEZE_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic run_pixel(input int mode, input int gap_pct, input bit stall, input int n_beats);
        logic signed [W-1:0] acts [0:CH-1];
        exp_t                e;
        longint              sum;
        bit                  sweep_ok;
        bit                  acc_seen;
        bit                  stall_ok;
        int                  bad_addr;
        int                  budget;
        logic signed [W-1:0] snap [0:N-1];
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: w_tab[c][i] = 16'sd256;
                    1, 2: w_tab[c][i] = 16'sd32767;
                    3: w_tab[c][i] = 16'(i * 256);
                    4: w_tab[c][i] = 16'(int'($urandom_range(2047)) - 1024);
                    default: w_tab[c][i] = 16'($urandom);
                endcase
            end
            case (mode)
                0: acts[c] = 16'sd2;
                1: acts[c] = 16'sd32767;
                2: acts[c] = -16'sd32768;
                3: acts[c] = 16'sd1;
                4: acts[c] = 16'(int'($urandom_range(599)) - 300);
                default: acts[c] = 16'($urandom);
            endcase
        end
        if (n_beats == CH) begin
            for (int i = 0; i < N; i++) begin
                sum = 0;
                for (int c = 0; c < CH; c++) sum += longint'(acts[c]) * longint'(w_tab[c][i]);
                e.v[i*W +: W] = W'(ref_result(sum));
            end
            e.last = (exp_pix == PIXN - 1);
            exp_pix = (exp_pix + 1) % PIXN;
            exp_q.push_back(e);
        end
        if (stall) res_ready = 1'b0;
        sweep_ok = 1'b1;
        bad_addr = 0;
        for (int c = 0; c < n_beats; c++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                act_valid = 1'b0;
                act_in = 16'($urandom);
                @(posedge clk); #1;
            end
            act_valid = 1'b1;
            act_in = acts[c];
            budget = 0;
            do begin
                @(negedge clk);
                acc_seen = act_ready;
                if (acc_seen && rom_addr != A'(c)) begin
                    sweep_ok = 1'b0;
                    bad_addr = int'(rom_addr);
                end
                @(posedge clk); #1;
                budget++;
            end while (!acc_seen && budget < 1000);
            if (!acc_seen) begin
                chk("accept_timeout", 1'b0, 0, 1);
                break;
            end
        end
        act_valid = 1'b0;
        chk("rom_addr_sweep", sweep_ok, bad_addr, 0);
        if (n_beats != CH) return;
        @(negedge clk);
        chk("latency_res_valid", res_valid == 1'b1, res_valid, 1);
        if (stall) begin
            for (int i = 0; i < N; i++) snap[i] = res_out[i];
            act_valid = 1'b1;
            act_in = 16'($urandom);
            stall_ok = 1'b1;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (act_ready || !res_valid) stall_ok = 1'b0;
                for (int i = 0; i < N; i++) if (res_out[i] != snap[i]) stall_ok = 1'b0;
            end
            chk("stall_hold", stall_ok, 0, 1);
            act_valid = 1'b0;
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(posedge clk); #1;
            chk("after_handshake_valid", res_valid == 1'b0, res_valid, 0);
        end else begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("one_cycle_valid", res_valid == 1'b0, res_valid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   ok;
        longint a_v;
        longint e_v;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1'b0, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    ok = 1'b1;
                    a_v = 0;
                    e_v = 0;
                    for (int i = 0; i < N; i++) begin
                        if (res_out[i] != $signed(e.v[i*W +: W]) && ok) begin
                            ok = 1'b0;
                            a_v = longint'(res_out[i]);
                            e_v = longint'($signed(e.v[i*W +: W]));
                        end
                    end
                    chk("res_out", ok, a_v, e_v);
                    chk("res_last", res_last == e.last, res_last, e.last);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit zero_ok;
        int budget;
        for (int c = 0; c < CH; c++) for (int i = 0; i < N; i++) w_tab[c][i] = '0;
        #23;
        zero_ok = (res_valid == 1'b0) && (res_last == 1'b0) && (busy == 1'b0) && (rom_addr == '0);
        for (int i = 0; i < N; i++) if (res_out[i] != '0) zero_ok = 1'b0;
        chk("reset_state", zero_ok, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_pixel(0, 0, 1'b0, CH);
        run_pixel(1, 0, 1'b0, CH);
        run_pixel(2, 0, 1'b1, CH);
        run_pixel(3, 0, 1'b0, CH);
        run_pixel(3, 30, 1'b0, CH);
        run_pixel(4, 10, 1'b0, CH);
        run_pixel(5, 0, 1'b0, CH);

        run_pixel(0, 0, 1'b0, 60);
        chk("busy_mid_pixel", busy == 1'b1, busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        zero_ok = (res_valid == 1'b0) && (res_last == 1'b0) && (busy == 1'b0) && (rom_addr == '0);
        for (int i = 0; i < N; i++) if (res_out[i] != '0) zero_ok = 1'b0;
        chk("async_reset_clear", zero_ok, 0, 1);
        exp_pix = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_pixel(0, 0, 1'b0, CH);
        run_pixel(4, 30, 1'b0, CH);
        run_pixel(4, 0, 1'b0, CH);
        run_pixel(5, 20, 1'b0, CH);

        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
